// File: rtl/joy2quad_pkg.sv
// Shared types and helpers for the joystick-to-quadrature steering encoder.
package joy2quad_pkg;

  // Per-channel stepping state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_FAST = 2'd2
  } state_e;

  // Signed step direction: +1, -1 or 0.
  typedef logic signed [1:0] dir_t;

  localparam dir_t DIR_NONE = 2'sb00;
  localparam dir_t DIR_POS  = 2'sb01;
  localparam dir_t DIR_NEG  = 2'sb11;

  // Gray-code the 2-bit phase into the quadrature pair {A,B}.
  function automatic logic [1:0] quad_out(input logic [1:0] phase);
    return {phase[1], phase[1] ^ phase[0]};
  endfunction

endpackage

// File: rtl/joy2quad_multi_channel.sv
// One steering channel: direction decode, FSM, step divider, step counter, phase.
module quad_step_channel
  import joy2quad_pkg::*;
#(
  parameter int unsigned DIV_W       = 17,
  parameter int unsigned ACCEL_STEPS = 16,
  parameter int unsigned STEP_W      = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [DIV_W-1:0] clkdiv_slow_i,
  input  logic [DIV_W-1:0] clkdiv_fast_i,
  input  logic             accel_en_i,
  input  logic             left_i,
  input  logic             right_i,
  input  logic             invert_i,
  output logic             steer_a_o,
  output logic             steer_b_o,
  output logic             moving_o
);

  localparam logic [STEP_W-1:0] STEPS_MAX = STEP_W'(ACCEL_STEPS);

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [1:0]          phase_q, phase_d;
  dir_t                cur_dir_q, cur_dir_d;
  logic                a_q, b_q, moving_q;

  logic                req_pos_c, req_neg_c;
  dir_t                dir_c;
  logic [DIV_W-1:0]    div_raw_c, div_last_c;
  logic                step_c;
  logic                hold_c;
  logic [STEP_W-1:0]   steps_inc_c;

  // Invert simply swaps which button means positive.
  assign req_pos_c = invert_i ? left_i  : right_i;
  assign req_neg_c = invert_i ? right_i : left_i;

  // Requested direction; both or neither pressed means stop.
  always_comb begin
    dir_c = DIR_NONE;
    if (req_pos_c && !req_neg_c) begin
      dir_c = DIR_POS;
    end else if (req_neg_c && !req_pos_c) begin
      dir_c = DIR_NEG;
    end
  end

  // Divider terminal count; a zero period behaves as one, and >= tolerates live shrinking.
  assign div_raw_c   = (state_q == ST_FAST) ? clkdiv_fast_i : clkdiv_slow_i;
  assign div_last_c  = (div_raw_c == '0) ? '0 : div_raw_c - DIV_W'(1);
  assign step_c      = (cnt_q >= div_last_c);
  assign steps_inc_c = (steps_q >= STEPS_MAX) ? STEPS_MAX : steps_q + STEP_W'(1);
  // Dropping out of FAST spends one edge holding the counter.
  assign hold_c      = (state_q == ST_FAST) && !accel_en_i;

  // State register.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dir_c != DIR_NONE) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        if (dir_c == DIR_NONE) begin
          state_d = ST_IDLE;
        end else if (dir_c != cur_dir_q) begin
          state_d = ST_RAMP;
        end else if (step_c && accel_en_i && (steps_inc_c == STEPS_MAX)) begin
          state_d = ST_FAST;
        end
      end
      ST_FAST: begin
        if (dir_c == DIR_NONE) begin
          state_d = ST_IDLE;
        end else if ((dir_c != cur_dir_q) || !accel_en_i) begin
          state_d = ST_RAMP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: divider count, step count, phase and latched direction.
  always_comb begin
    cnt_d     = cnt_q;
    steps_d   = steps_q;
    phase_d   = phase_q;
    cur_dir_d = cur_dir_q;
    case (state_q)
      ST_IDLE: begin
        if (dir_c != DIR_NONE) begin
          cnt_d     = '0;
          steps_d   = '0;
          cur_dir_d = dir_c;
        end
      end
      default: begin
        if (dir_c == DIR_NONE) begin
          cnt_d = '0;
        end else if (dir_c != cur_dir_q) begin
          cnt_d     = '0;
          steps_d   = '0;
          cur_dir_d = dir_c;
        end else if (!hold_c) begin
          if (step_c) begin
            cnt_d   = '0;
            phase_d = phase_q + $unsigned(cur_dir_q);
            steps_d = steps_inc_c;
          end else begin
            cnt_d = cnt_q + DIV_W'(1);
          end
        end
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      steps_q   <= '0;
      phase_q   <= '0;
      cur_dir_q <= DIR_NONE;
    end else begin
      cnt_q     <= cnt_d;
      steps_q   <= steps_d;
      phase_q   <= phase_d;
      cur_dir_q <= cur_dir_d;
    end
  end

  // Registered outputs, aligned with the phase and state registers.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      moving_q <= 1'b0;
    end else begin
      {a_q, b_q} <= quad_out(phase_d);
      moving_q   <= (state_d != ST_IDLE);
    end
  end

  assign steer_a_o = a_q;
  assign steer_b_o = b_q;
  assign moving_o  = moving_q;

endmodule

// File: rtl/joy2quad_multi.sv
// N-channel joystick-to-quadrature steering encoder; channels share divider and accel controls.
module joy2quad_multi
  import joy2quad_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DIV_W       = 17,
  parameter int unsigned ACCEL_STEPS = 16,
  parameter int unsigned STEP_W      = 8
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [DIV_W-1:0]    clkdiv_slow,
  input  logic [DIV_W-1:0]    clkdiv_fast,
  input  logic                accel_en,
  input  logic [CHANNELS-1:0] left,
  input  logic [CHANNELS-1:0] right,
  input  logic [CHANNELS-1:0] invert,
  output logic [CHANNELS-1:0] steerA,
  output logic [CHANNELS-1:0] steerB,
  output logic [CHANNELS-1:0] moving
);

  // One independent stepper per channel.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    quad_step_channel #(
      .DIV_W       (DIV_W),
      .ACCEL_STEPS (ACCEL_STEPS),
      .STEP_W      (STEP_W)
    ) u_ch (
      .clk_sys       (clk_sys),
      .reset         (reset),
      .clkdiv_slow_i (clkdiv_slow),
      .clkdiv_fast_i (clkdiv_fast),
      .accel_en_i    (accel_en),
      .left_i        (left[g]),
      .right_i       (right[g]),
      .invert_i      (invert[g]),
      .steer_a_o     (steerA[g]),
      .steer_b_o     (steerB[g]),
      .moving_o      (moving[g])
    );
  end

endmodule

// File: tb/tb_joy2quad_multi.sv
// Bench for joy2quad_multi: directed scenarios with literal expectations plus randomized traffic vs. a model.
module tb_joy2quad_multi;

  localparam int unsigned CH = 2;
  localparam int unsigned DW = 17;
  localparam int unsigned AS = 4;
  localparam int unsigned SW = 8;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [DW-1:0] clkdiv_slow, clkdiv_fast;
  logic          accel_en;
  logic [CH-1:0] left, right, invert;
  logic [CH-1:0] steerA, steerB, moving;

  int vectors = 0;
  int miscompares = 0;

  // Quadrature sequence for phase 0..3 going forward: 00,01,11,10.
  int pos_seq[4] = '{0, 1, 3, 2};

  // Model state per channel: moving, fast, divider count, steps, phase, latched direction.
  int m_mv[CH], m_fast[CH], m_cnt[CH], m_stp[CH], m_ph[CH], m_cd[CH];

  joy2quad_multi #(
    .CHANNELS    (CH),
    .DIV_W       (DW),
    .ACCEL_STEPS (AS),
    .STEP_W      (SW)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .clkdiv_slow (clkdiv_slow),
    .clkdiv_fast (clkdiv_fast),
    .accel_en    (accel_en),
    .left        (left),
    .right       (right),
    .invert      (invert),
    .steerA      (steerA),
    .steerB      (steerB),
    .moving      (moving)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic int ab(input int ch);
    return int'({steerA[ch], steerB[ch]});
  endfunction

  function automatic int neg_seq(input int k);
    return pos_seq[(4 - (k % 4)) % 4];
  endfunction

  // Behavioural model: what each channel must do on every rising edge.
  always @(posedge clk_sys or posedge reset) begin : mdl
    int d, dv;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        m_mv[c] = 0; m_fast[c] = 0; m_cnt[c] = 0;
        m_stp[c] = 0; m_ph[c] = 0; m_cd[c] = 0;
      end
    end else begin
      for (int c = 0; c < CH; c++) begin
        d = 0;
        if (right[c] && !left[c]) d = 1;
        else if (left[c] && !right[c]) d = -1;
        if (invert[c]) d = -d;
        if (m_mv[c] == 0) begin
          if (d != 0) begin
            m_mv[c] = 1; m_fast[c] = 0; m_cnt[c] = 0; m_stp[c] = 0; m_cd[c] = d;
          end
        end else if (d == 0) begin
          m_mv[c] = 0; m_fast[c] = 0; m_cnt[c] = 0;
        end else if (d != m_cd[c]) begin
          m_fast[c] = 0; m_cnt[c] = 0; m_stp[c] = 0; m_cd[c] = d;
        end else if (m_fast[c] != 0 && !accel_en) begin
          m_fast[c] = 0;
        end else begin
          dv = (m_fast[c] != 0) ? int'(clkdiv_fast) : int'(clkdiv_slow);
          if (dv == 0) dv = 1;
          if (m_cnt[c] >= dv - 1) begin
            m_cnt[c] = 0;
            m_ph[c]  = (m_ph[c] + m_cd[c] + 4) % 4;
            m_stp[c] = (m_stp[c] + 1 > int'(AS)) ? int'(AS) : m_stp[c] + 1;
            if (m_fast[c] == 0 && accel_en && m_stp[c] == int'(AS)) m_fast[c] = 1;
          end else begin
            m_cnt[c] = m_cnt[c] + 1;
          end
        end
      end
    end
  end

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk_sys) begin : cmp
    logic [CH-1:0] ea, eb, em;
    for (int c = 0; c < CH; c++) begin
      ea[c] = (m_ph[c] == 2) || (m_ph[c] == 3);
      eb[c] = (m_ph[c] == 1) || (m_ph[c] == 2);
      em[c] = (m_mv[c] != 0);
    end
    check("model_cmp", int'({steerA, steerB, moving}), int'({ea, eb, em}));
  end

  initial begin
    reset       = 1'b1;
    left        = '0;
    right       = 2'b01;
    invert      = '0;
    clkdiv_slow = DW'(4);
    clkdiv_fast = DW'(2);
    accel_en    = 1'b0;

    // Reset held with right pressed.
    repeat (3) @(negedge clk_sys);
    check("reset_held", int'({steerA, steerB, moving}), 0);
    reset = 1'b0;
    #1 check("release_pre_entry", int'({steerA, steerB, moving}), 0);

    // Right held, period 4.
    @(negedge clk_sys);
    check("entry_moving", int'(moving), 1);
    check("entry_ab", ab(0), 0);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) @(negedge clk_sys);
      check("slow_pre_step", ab(0), pos_seq[(k - 1) % 4]);
      @(negedge clk_sys);
      check("slow_step", ab(0), pos_seq[k % 4]);
    end
    right = '0;
    @(negedge clk_sys);
    check("stop_moving", int'(moving), 0);

    // Acceleration: four 8-cycle steps then 2-cycle steps, reverse sequence.
    clkdiv_slow = DW'(8);
    clkdiv_fast = DW'(2);
    accel_en    = 1'b1;
    left        = 2'b01;
    @(negedge clk_sys);
    check("accel_entry", int'(moving), 1);
    for (int k = 1; k <= 8; k++) begin
      repeat (((k <= 4) ? 8 : 2) - 1) @(negedge clk_sys);
      check("accel_pre_step", ab(0), neg_seq(k - 1));
      @(negedge clk_sys);
      check("accel_step", ab(0), neg_seq(k));
    end
    left     = '0;
    accel_en = 1'b0;
    @(negedge clk_sys);

    // Reversal mid-count, then both pressed.
    clkdiv_slow = DW'(4);
    right       = 2'b01;
    @(negedge clk_sys);
    repeat (2) @(negedge clk_sys);
    right = '0;
    left  = 2'b01;
    @(negedge clk_sys);
    check("rev_switch_ab", ab(0), 0);
    check("rev_switch_moving", int'(moving), 1);
    repeat (3) @(negedge clk_sys);
    check("rev_pre_step", ab(0), 0);
    @(negedge clk_sys);
    check("rev_first_step", ab(0), 2);
    right = 2'b01;
    @(negedge clk_sys);
    check("both_moving", int'(moving), 0);
    repeat (5) @(negedge clk_sys);
    check("both_frozen", ab(0), 2);
    left  = '0;
    right = '0;
    @(negedge clk_sys);

    // Zero divider: step every cycle after entry (phase starts at 3).
    clkdiv_slow = '0;
    right       = 2'b01;
    @(negedge clk_sys);
    check("div0_entry", ab(0), 2);
    @(negedge clk_sys);
    check("div0_step1", ab(0), 0);
    @(negedge clk_sys);
    check("div0_step2", ab(0), 1);
    @(negedge clk_sys);
    check("div0_step3", ab(0), 3);
    right = '0;
    @(negedge clk_sys);
    check("div0_stop", int'({moving[0], steerA[0], steerB[0]}), 3);

    // Live reduction of the period from 100 to 5 at cnt=50.
    clkdiv_slow = DW'(100);
    right       = 2'b01;
    @(negedge clk_sys);
    repeat (50) @(negedge clk_sys);
    check("reduce_before", ab(0), 3);
    clkdiv_slow = DW'(5);
    @(negedge clk_sys);
    check("reduce_step", ab(0), 2);
    repeat (4) @(negedge clk_sys);
    check("reduce_hold", ab(0), 2);
    @(negedge clk_sys);
    check("reduce_period5", ab(0), 0);

    // Asynchronous reset mid-run.
    repeat (2) @(negedge clk_sys);
    #2 reset = 1'b1;
    #1 check("async_reset", int'({steerA, steerB, moving}), 0);
    @(negedge clk_sys);
    right = '0;
    reset = 1'b0;
    @(negedge clk_sys);

    // Channel 1 inverted right, period 3; channel 0 idle.
    clkdiv_slow = DW'(3);
    invert      = 2'b10;
    right       = 2'b10;
    @(negedge clk_sys);
    check("inv_entry_moving", int'(moving), 2);
    for (int k = 1; k <= 4; k++) begin
      repeat (3) @(negedge clk_sys);
      check("inv_ch1_step", ab(1), neg_seq(k));
      check("inv_ch0_idle", int'({moving[0], steerA[0], steerB[0]}), 0);
    end
    right  = '0;
    invert = '0;
    @(negedge clk_sys);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) left   = CH'($urandom);
      if ($urandom_range(0, 7) == 0) right  = CH'($urandom);
      if ($urandom_range(0, 15) == 0) invert = CH'($urandom);
      if ($urandom_range(0, 31) == 0) clkdiv_slow = DW'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0) clkdiv_fast = DW'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) accel_en = ~accel_en;
      @(negedge clk_sys);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/joy2quad_multi.md
Name: joy2quad_multi

Overview:
- Parametrised successor to the single-channel joystick-to-quadrature steering encoder used by the BW raster arcade cores.
- Converts N digital left/right controls into N quadrature steering pairs (A/B) for cores expecting optical steering wheels.
- Adds per-channel speed acceleration, direction inversion, reversal handling and a "moving" status.
- Sits between arcade_inputs and the game core, in the clk_sys domain.

Parameters:
- CHANNELS, 2, number of independent steering channels.
- DIV_W, 17, width of the step-period dividers (cycles per quadrature step).
- ACCEL_STEPS, 16, number of slow-rate steps emitted before switching to the fast rate.
- STEP_W, 8, width of the per-channel step counter; must hold ACCEL_STEPS.

Ports:
- clk_sys  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- clkdiv_slow  in  DIV_W  step period in cycles before acceleration.
- clkdiv_fast  in  DIV_W  step period in cycles after acceleration.
- accel_en  in  1  1 = ramp to fast rate; 0 = always use slow rate.
- left  in  CHANNELS  per-channel left request, active-high.
- right  in  CHANNELS  per-channel right request, active-high.
- invert  in  CHANNELS  per-channel direction swap.
- steerA  out  CHANNELS  quadrature phase A.
- steerB  out  CHANNELS  quadrature phase B.
- moving  out  CHANNELS  1 while a channel is in RAMP or FAST.

Behaviour:
- Reset (async assert, sync release): every channel is IDLE with phase=0, cnt=0 and steps=0. Outputs steerA=0, steerB=0, moving=0.
- Per channel, dir = right&~left gives +1; left&~right gives -1; none or both gives 0. invert negates a nonzero dir. Inputs are sampled directly, with no synchroniser, because they already come from the clk_sys domain.
- The 2-bit phase maps to outputs as A=phase[1], B=phase[1]^phase[0]. Stepping +1 gives (A,B) = 00,01,11,10,00…; stepping -1 gives the reverse. Phase wraps modulo 4.
- States are IDLE, RAMP and FAST.
  - IDLE to RAMP: on an edge where dir≠0. On that edge cnt←0, steps←0, and dir is latched into cur_dir.
  - RAMP/FAST to IDLE: on an edge where dir=0. cnt←0 and phase is held (no step on that edge).
  - RAMP/FAST with dir≠0 and dir≠cur_dir (reversal): go to RAMP with cnt←0, steps←0 and cur_dir←dir. No step on that edge.
  - RAMP to FAST: on the step edge where steps reaches ACCEL_STEPS, if accel_en=1. If accel_en=0, the channel stays in RAMP and steps saturates.
  - FAST: if accel_en falls, return to RAMP on the next edge, keeping cnt.
- Divider: div = clkdiv_slow in RAMP, clkdiv_fast in FAST. An effective div of 0 is treated as 1.
  - Each edge in RAMP/FAST: if cnt ≥ div-1, then cnt←0, phase←phase+cur_dir and steps←sat(steps+1). Otherwise cnt←cnt+1.
  - The ≥ comparison makes a live reduction of div take effect immediately, without a wrap-around stall.
- Latency: the first phase change occurs exactly div edges after the entry edge. Steady period is div cycles.
- moving is registered with state and asserts on the entry edge.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset mid-step forces the reset values immediately, regardless of the clock.

Decomposition:
- Package joy2quad_pkg contains:
  - the state enum (IDLE, RAMP, FAST);
  - the dir type (2-bit signed);
  - the function quad_out(phase) returning {A,B}.
- Sub-module quad_step_channel holds one channel's FSM, divider, step counter and phase. The top instantiates it CHANNELS times with a generate loop and shares the divider and accel inputs across channels.

Test Plan:
- Reset: assert reset with right=1, CHANNELS=2 → steerA=0, steerB=0, moving=0 while reset is held and on release until the entry edge.
- Right held, clkdiv_slow=4, accel_en=0:
  - moving=1 from the entry edge;
  - (A,B) = 01 at +4 cycles, 11 at +8, 10 at +12, 00 at +16;
  - period 4 sustained.
- Acceleration: clkdiv_slow=8, clkdiv_fast=2, ACCEL_STEPS=4, accel_en=1, left held → 4 steps at 8-cycle spacing, then steps every 2 cycles, with reverse sequence 10,11,01,00.
- Reversal and both pressed:
  - switch right to left mid-count → no step on the switch edge; the first reverse step comes 4 cycles later.
  - left=right=1 → moving=0 next edge and phase frozen.
- invert[1]=1 with right[1]=1 on channel 1 only, clkdiv_slow=3 → channel 1 steps in the -1 sequence every 3 cycles; channel 0 outputs stay 00.
- Divider edge cases:
  - clkdiv_slow=0 → step every cycle.
  - reduce clkdiv_slow from 100 to 5 while cnt=50 → step on the next edge.
  - async reset mid-run → outputs 00 immediately.
